// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Two-master / one-slave bus arbiter. Master 0 is instruction fetch, master 1
// is the load/store unit. Requests are serialised with round-robin fairness,
// one transaction is outstanding at a time, and each response is routed back
// to the master that issued it.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   When defined, a transaction that spends TIMEOUT_CYCLES cycles in REQ+RSP
//   without a slave response is aborted with an error response (err_o=1,
//   rdata=0). When undefined, err_o is tied to 0 and the arbiter waits forever.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   mX_req_i/we_i/addr_i/   master request channel (held until mX_gnt_o)
//   wdata_i/be_i
//   mX_gnt_o                1-cycle accept pulse, combinational in IDLE
//   mX_rvalid_o/rdata_o/    registered response; rdata holds between responses
//   err_o
//   s_req_o/we_o/addr_o/    slave request channel, driven from latched fields
//   wdata_o/be_o
//   s_gnt_i, s_rvalid_i,    slave accept / response (rvalid for reads and
//   s_rdata_i               writes)
//
// States:
//   S_IDLE | no transaction; arbitrate and grant
//   S_REQ  | s_req_o high, waiting for s_gnt_i
//   S_RSP  | accepted by slave, waiting for s_rvalid_i
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_err_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_err_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_be_o,
    input  logic                s_gnt_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic                        owner_q, owner_d;
    logic                        last_q, last_d;
    logic                        s_we_q, s_we_d;
    logic [ADDR_W-1:0]           s_addr_q, s_addr_d;
    logic [DATA_W-1:0]           s_wdata_q, s_wdata_d;
    logic [BE_W-1:0]             s_be_q, s_be_d;
    logic [1:0]                  rvalid_q, rvalid_d;
    logic [1:0][DATA_W-1:0]      rdata_q, rdata_d;
    logic [1:0]                  gnt;
    logic                        winner;
    logic                        any_req;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [1:0]                  err_q, err_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        timeout;

    // A response arriving in the limit cycle takes priority over the abort.
    assign timeout = (state_q != S_IDLE) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                     !((state_q == S_RSP) && s_rvalid_i);
    assign cnt_d   = (state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
`endif

    assign any_req = m0_req_i | m1_req_i;
    // On a tie the master that was not granted last wins.
    assign winner  = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_be_d    = s_be_q;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        gnt       = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        err_d     = '0;
`endif
        case (state_q)
            S_IDLE: begin
                // Grant is suppressed during reset so every output reads 0.
                if (any_req && !rst_i) begin
                    gnt[winner] = 1'b1;
                    owner_d     = winner;
                    last_d      = winner;
                    s_we_d      = winner ? m1_we_i    : m0_we_i;
                    s_addr_d    = winner ? m1_addr_i  : m0_addr_i;
                    s_wdata_d   = winner ? m1_wdata_i : m0_wdata_i;
                    s_be_d      = winner ? m1_be_i    : m0_be_i;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (s_gnt_i) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (s_rvalid_i) begin
                    rvalid_d[owner_q] = 1'b1;
                    rdata_d[owner_q]  = s_rdata_i;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef MEM_ARB_TIMEOUT_EN
        if (timeout) begin
            rvalid_d[owner_q] = 1'b1;
            err_d[owner_q]    = 1'b1;
            rdata_d[owner_q]  = '0;
            state_d           = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_be_q    <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q     <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_be_q    <= s_be_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign m0_rvalid_o = rvalid_q[0];
    assign m1_rvalid_o = rvalid_q[1];
    assign m0_rdata_o  = rdata_q[0];
    assign m1_rdata_o  = rdata_q[1];
`ifdef MEM_ARB_TIMEOUT_EN
    assign m0_err_o    = err_q[0];
    assign m1_err_o    = err_q[1];
`else
    assign m0_err_o    = 1'b0;
    assign m1_err_o    = 1'b0;
`endif
    assign s_req_o     = (state_q == S_REQ);
    assign s_we_o      = s_we_q;
    assign s_addr_o    = s_addr_q;
    assign s_wdata_o   = s_wdata_q;
    assign s_be_o      = s_be_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter sharing the single memory/peripheral bus between instruction fetch (master 0) and the load/store unit (master 1).
- Sits upstream of the address decoder and data memory.
- Serialises requests with round-robin fairness and allows one outstanding transaction at a time.
- Routes each response back to the master that issued it.

Parameters:
- ADDR_W, 32, address width of masters and slave
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 16, cycles in REQ+RSP before timeout abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- m0_req_i / m1_req_i  input  1  master request
- m0_we_i / m1_we_i  input  1  write enable
- m0_addr_i / m1_addr_i  input  ADDR_W  address
- m0_wdata_i / m1_wdata_i  input  DATA_W  write data
- m0_be_i / m1_be_i  input  DATA_W/8  byte enables
- m0_gnt_o / m1_gnt_o  output  1  request accepted (1-cycle pulse)
- m0_rvalid_o / m1_rvalid_o  output  1  response valid (1-cycle pulse)
- m0_rdata_o / m1_rdata_o  output  DATA_W  read data
- m0_err_o / m1_err_o  output  1  response is a timeout error
- s_req_o  output  1  slave request
- s_we_o  output  1  slave write enable
- s_addr_o  output  ADDR_W  slave address
- s_wdata_o  output  DATA_W  slave write data
- s_be_o  output  DATA_W/8  slave byte enables
- s_gnt_i  input  1  slave accepted request
- s_rvalid_i  input  1  slave response valid; asserted for reads and writes
- s_rdata_i  input  DATA_W  slave read data

Behaviour:
- Single clock clk_i; reset rst_i is synchronous, active-high.
- Reset state:
  - FSM=IDLE, owner=0, last_grant=1 (so m0 wins the first tie).
  - All *_o = 0, including registered rdata and err; timeout counter = 0.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - If any mX_req_i=1, pick a winner. A single requester wins. If both request, the master that is not last_grant wins.
  - winner_gnt_o = 1 combinationally in the same cycle.
  - At the clock edge: latch the winner's we/addr/wdata/be into the slave registers, set owner=winner, set last_grant=winner, go to REQ.
  - Loser's gnt_o = 0. The loser must hold its request.
- REQ:
  - s_req_o=1, driving latched fields; latched fields are stable until s_gnt_i.
  - On s_gnt_i=1: next cycle s_req_o=0, go to RSP.
- RSP:
  - On s_rvalid_i=1: register s_rdata_i into owner's rdata, pulse owner's rvalid_o=1 for exactly one cycle (the cycle after s_rvalid_i), go to IDLE.
  - Non-owner rvalid_o stays 0.
- Latency (zero-wait slave that grants immediately and responds the next cycle):
  - req (c0) -> gnt_o (c0), s_req_o (c1), s_gnt_i (c1), s_rvalid_i (c2), mX_rvalid_o (c3).
  - Next grant possible at c3, while in IDLE.
- rdata_o holds its last value between responses. Masters sample it only with rvalid_o.
- Slave protocol violations:
  - s_rvalid_i in IDLE or REQ is ignored.
  - s_gnt_i outside REQ is ignored.
- Simultaneous rvalid and new request: IDLE is only entered after the response, so a new grant occurs no earlier than the cycle rvalid_o is high.
- Reset mid-transaction: the transaction is dropped and no rvalid is issued. The FSM goes to IDLE and s_req_o drops the next cycle.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN
- Defined:
  - Counter clears on entering REQ and increments each cycle in REQ/RSP.
  - When the counter reaches TIMEOUT_CYCLES without s_rvalid_i: pulse owner's rvalid_o=1 and err_o=1 with rdata=0, drop s_req_o, go to IDLE.
  - A late s_rvalid_i is then ignored.
  - If s_rvalid_i arrives in the same cycle as the counter hits the limit, the normal response wins (err=0).
  - err_o=0 on all normal responses.
- Undefined: no counter; err_o tied 0; the FSM waits indefinitely.

Test Plan:
- Single read m0: req addr=0x10, slave gnt immediate, rvalid next cycle with rdata=0xDEADBEEF -> m0_gnt_o at c0, s_addr_o=0x10 at c1, m0_rvalid_o with 0xDEADBEEF at c3, m1 outputs stay 0.
- Contention: m0 and m1 request together from reset, both held -> m0 granted first, then m1, then m0 (alternating). s_addr_o follows, and each response reaches only its owner.
- Slave stall: s_gnt_i held 0 for 5 cycles, write addr=0x80000000 wdata=0x5 be=0xF -> s_req_o and fields stable for all 6 cycles, no second grant until rvalid.
- Reset mid-RSP: rst_i asserted while awaiting rvalid, then s_rvalid_i pulsed -> no mX_rvalid_o, all outputs 0, next request granted to m0.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave never responds -> owner rvalid_o=1, err_o=1, rdata=0 exactly 16 cycles after entering REQ; without the macro, no response and err_o always 0.
- Spurious slave signals: s_rvalid_i and s_gnt_i pulsed in IDLE -> no rvalid_o, state unchanged.
